// File: rtl/vram_arbiter_if.sv
// Request/response bundle for the shared PVR VRAM port.
// slave = arbiter side, master = requesters and VRAM side.
interface vram_arbiter_if;
  logic        cpu_req_valid;
  logic [22:0] cpu_req_addr;
  logic        cpu_req_wen;
  logic [63:0] cpu_req_wdata;
  logic [7:0]  cpu_req_wmask;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [63:0] cpu_resp_rdata;

  logic        pvr_req_valid;
  logic [22:0] pvr_req_addr;
  logic        pvr_req_ready;
  logic        pvr_resp_valid;
  logic [31:0] pvr_resp_rdata;

  logic        vram_rd;
  logic        vram_wr;
  logic [22:0] vram_addr;
  logic [31:0] vram_dout;
  logic [3:0]  vram_be;
  logic [31:0] vram_din;
  logic        vram_ack;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_wen, cpu_req_wdata, cpu_req_wmask,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  pvr_req_valid, pvr_req_addr,
    output pvr_req_ready, pvr_resp_valid, pvr_resp_rdata,
    output vram_rd, vram_wr, vram_addr, vram_dout, vram_be,
    input  vram_din, vram_ack
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_wen, cpu_req_wdata, cpu_req_wmask,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output pvr_req_valid, pvr_req_addr,
    input  pvr_req_ready, pvr_resp_valid, pvr_resp_rdata,
    input  vram_rd, vram_wr, vram_addr, vram_dout, vram_be,
    output vram_din, vram_ack
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the 32-bit PVR VRAM port between the SH4 64-bit data path and the PVR fetch engine.
// IDLE arbitrate | CPU_LO beat addr+0 | CPU_HI beat addr+4 | PVR read beat | RESP response pulse
module vram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);

  localparam int WCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] W_LIMIT = WCW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CPU_LO = 3'd1,
    S_CPU_HI = 3'd2,
    S_PVR    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [22:0]    r_addr;
  logic [63:0]    r_wdata;
  logic [7:0]     r_wmask;
  logic           r_wen;
  logic           r_owner_cpu;

  logic           r_vram_rd;
  logic           r_vram_wr;
  logic [22:0]    r_vram_addr;
  logic [31:0]    r_vram_dout;
  logic [3:0]     r_vram_be;
  logic           r_cpu_resp_valid;
  logic [63:0]    r_cpu_rdata;
  logic           r_pvr_resp_valid;
  logic [31:0]    r_pvr_rdata;

  logic           w_starve;
  logic           w_cpu_gnt;
  logic           w_pvr_gnt;
  logic [22:0]    w_eff_addr;
  logic [63:0]    w_eff_wdata;
  logic [7:0]     w_eff_wmask;
  logic           w_eff_wen;
  logic           w_eff_owner_cpu;
  logic           w_rd_nxt;
  logic           w_wr_nxt;
  logic [22:0]    w_addr_nxt;
  logic [31:0]    w_dout_nxt;
  logic [3:0]     w_be_nxt;
  logic           w_unused_addr_bits;

  assign w_starve = (r_wait_cnt >= W_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cpu_gnt   = 1'b0;
    w_pvr_gnt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req_valid && (!bus.pvr_req_valid || w_starve)) begin
          w_cpu_gnt = 1'b1;
          // Writes skip beats whose byte-enable nibble is empty
          if (!bus.cpu_req_wen || (bus.cpu_req_wmask[3:0] != 4'h0)) begin
            w_state_nxt = S_CPU_LO;
          end else if (bus.cpu_req_wmask[7:4] != 4'h0) begin
            w_state_nxt = S_CPU_HI;
          end else begin
            w_state_nxt = S_RESP;
          end
        end else if (bus.pvr_req_valid) begin
          w_pvr_gnt   = 1'b1;
          w_state_nxt = S_PVR;
        end
      end
      S_CPU_LO: begin
        if (bus.vram_ack) begin
          w_state_nxt = (r_wen && (r_wmask[7:4] == 4'h0)) ? S_RESP : S_CPU_HI;
        end
      end
      S_CPU_HI, S_PVR: begin
        if (bus.vram_ack) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields seen by the beat logic: live inputs in the grant cycle, latched copies after
  assign w_eff_addr      = w_cpu_gnt ? bus.cpu_req_addr : (w_pvr_gnt ? bus.pvr_req_addr : r_addr);
  assign w_eff_wdata     = w_cpu_gnt ? bus.cpu_req_wdata : r_wdata;
  assign w_eff_wmask     = w_cpu_gnt ? bus.cpu_req_wmask : r_wmask;
  assign w_eff_wen       = w_cpu_gnt ? bus.cpu_req_wen : (w_pvr_gnt ? 1'b0 : r_wen);
  assign w_eff_owner_cpu = w_cpu_gnt | (~w_pvr_gnt & r_owner_cpu);
  assign w_unused_addr_bits = ^w_eff_addr[1:0];

  always_comb begin
    w_rd_nxt   = 1'b0;
    w_wr_nxt   = 1'b0;
    w_addr_nxt = r_vram_addr;
    w_dout_nxt = r_vram_dout;
    w_be_nxt   = r_vram_be;
    case (w_state_nxt)
      S_CPU_LO: begin
        w_rd_nxt   = ~w_eff_wen;
        w_wr_nxt   = w_eff_wen;
        w_addr_nxt = {w_eff_addr[22:3], 3'b000};
        w_dout_nxt = w_eff_wen ? w_eff_wdata[31:0] : 32'h0;
        w_be_nxt   = w_eff_wen ? w_eff_wmask[3:0] : 4'hF;
      end
      S_CPU_HI: begin
        w_rd_nxt   = ~w_eff_wen;
        w_wr_nxt   = w_eff_wen;
        w_addr_nxt = {w_eff_addr[22:3], 3'b100};
        w_dout_nxt = w_eff_wen ? w_eff_wdata[63:32] : 32'h0;
        w_be_nxt   = w_eff_wen ? w_eff_wmask[7:4] : 4'hF;
      end
      S_PVR: begin
        w_rd_nxt   = 1'b1;
        w_addr_nxt = {w_eff_addr[22:2], 2'b00};
        w_dout_nxt = 32'h0;
        w_be_nxt   = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt       <= '0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_wmask          <= '0;
      r_wen            <= 1'b0;
      r_owner_cpu      <= 1'b0;
      r_vram_rd        <= 1'b0;
      r_vram_wr        <= 1'b0;
      r_vram_addr      <= '0;
      r_vram_dout      <= '0;
      r_vram_be        <= '0;
      r_cpu_resp_valid <= 1'b0;
      r_cpu_rdata      <= '0;
      r_pvr_resp_valid <= 1'b0;
      r_pvr_rdata      <= '0;
    end else begin
      r_vram_rd        <= w_rd_nxt;
      r_vram_wr        <= w_wr_nxt;
      r_vram_addr      <= w_addr_nxt;
      r_vram_dout      <= w_dout_nxt;
      r_vram_be        <= w_be_nxt;
      r_cpu_resp_valid <= (w_state_nxt == S_RESP) &&  w_eff_owner_cpu;
      r_pvr_resp_valid <= (w_state_nxt == S_RESP) && !w_eff_owner_cpu;

      if (w_cpu_gnt) begin
        r_addr      <= bus.cpu_req_addr;
        r_wdata     <= bus.cpu_req_wdata;
        r_wmask     <= bus.cpu_req_wmask;
        r_wen       <= bus.cpu_req_wen;
        r_owner_cpu <= 1'b1;
        r_cpu_rdata <= '0;
      end else if (w_pvr_gnt) begin
        r_addr      <= bus.pvr_req_addr;
        r_wen       <= 1'b0;
        r_owner_cpu <= 1'b0;
      end

      if (bus.vram_ack && !r_wen) begin
        case (r_state)
          S_CPU_LO: r_cpu_rdata[31:0]  <= bus.vram_din;
          S_CPU_HI: r_cpu_rdata[63:32] <= bus.vram_din;
          S_PVR:    r_pvr_rdata        <= bus.vram_din;
          default: ;
        endcase
      end

      if (w_cpu_gnt) begin
        r_wait_cnt <= '0;
      end else if (bus.cpu_req_valid && !w_starve) begin
        r_wait_cnt <= r_wait_cnt + WCW'(1);
      end
    end
  end

  // Grants are combinational in IDLE but must stay low while reset is held
  assign bus.cpu_req_ready  = w_cpu_gnt & ~rst;
  assign bus.pvr_req_ready  = w_pvr_gnt & ~rst;
  assign bus.cpu_resp_valid = r_cpu_resp_valid;
  assign bus.cpu_resp_rdata = r_cpu_rdata;
  assign bus.pvr_resp_valid = r_pvr_resp_valid;
  assign bus.pvr_resp_rdata = r_pvr_rdata;
  assign bus.vram_rd        = r_vram_rd;
  assign bus.vram_wr        = r_vram_wr;
  assign bus.vram_addr      = r_vram_addr;
  assign bus.vram_dout      = r_vram_dout;
  assign bus.vram_be        = r_vram_be;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and randomized bench for vram_arbiter against a beat-queue / memory reference model.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_arbiter_if bus();

  vram_arbiter #(.STARVE_LIMIT(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wen   = 1'b0;
    bus.cpu_req_wdata = '0;
    bus.cpu_req_wmask = '0;
    bus.pvr_req_valid = 1'b0;
    bus.pvr_req_addr  = '0;
    bus.vram_din      = '0;
    bus.vram_ack      = 1'b0;
  endtask

  task automatic cpu_req(input logic [22:0] a, input logic wen, input logic [63:0] d, input logic [7:0] m);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = a;
    bus.cpu_req_wen   = wen;
    bus.cpu_req_wdata = d;
    bus.cpu_req_wmask = m;
  endtask

  // reference model state
  typedef struct packed {
    logic        wr;
    logic [22:0] addr;
    logic [31:0] dout;
    logic [3:0]  be;
  } beat_t;

  logic [31:0] mem [int];
  beat_t       beats[$];

  function automatic logic [31:0] read_mem(input int w);
    if (mem.exists(w)) return mem[w];
    return {8'hA5, 24'(w)};
  endfunction

  int          wcnt;
  bit          inflight, owner_cpu, cpu_pend, pvr_pend;
  bit          due_cpu, due_pvr, nxt_cpu, nxt_pvr, exp_cg, exp_pg, strobe;
  logic [63:0] exp_cpu_rdata;
  logic [31:0] exp_pvr_rdata, wv;
  logic [22:0] base;
  beat_t       b;
  int          ng;
  logic [4:0]  seq;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();

    // reset values, grants held off while in reset
    bus.cpu_req_valid = 1'b1;
    bus.pvr_req_valid = 1'b1;
    #1;
    check_eq("rst_ready",  {bus.cpu_req_ready, bus.pvr_req_ready}, 0);
    check_eq("rst_strobe", {bus.vram_rd, bus.vram_wr, bus.vram_be}, 0);
    check_eq("rst_addr",   bus.vram_addr, 0);
    check_eq("rst_dout",   bus.vram_dout, 0);
    check_eq("rst_resp",   {bus.cpu_resp_valid, bus.pvr_resp_valid}, 0);
    check_eq("rst_cpu_rd", bus.cpu_resp_rdata, 0);
    check_eq("rst_pvr_rd", bus.pvr_resp_rdata, 0);
    idle_inputs();
    rst = 1'b0;
    step();

    // PVR read, ack in first strobe cycle
    bus.pvr_req_valid = 1'b1;
    bus.pvr_req_addr  = 23'h000104;
    #1;
    check_eq("pvr_gnt", {bus.cpu_req_ready, bus.pvr_req_ready}, 2'b01);
    step();
    bus.pvr_req_valid = 1'b0;
    check_eq("pvr_strobe", {bus.vram_rd, bus.vram_wr, bus.vram_be}, {2'b10, 4'hF});
    check_eq("pvr_addr", bus.vram_addr, 23'h000104);
    bus.vram_ack = 1'b1;
    bus.vram_din = 32'hDEADBEEF;
    step();
    bus.vram_ack = 1'b0;
    check_eq("pvr_rd_drop", bus.vram_rd, 0);
    check_eq("pvr_resp", bus.pvr_resp_valid, 1);
    check_eq("pvr_data", bus.pvr_resp_rdata, 32'hDEADBEEF);
    step();
    check_eq("pvr_resp_end", bus.pvr_resp_valid, 0);

    // CPU read, low address bits ignored
    cpu_req(23'h000203, 1'b0, 64'h0, 8'hFF);
    #1;
    check_eq("cpurd_gnt", bus.cpu_req_ready, 1);
    step();
    bus.cpu_req_valid = 1'b0;
    check_eq("cpurd_lo", {bus.vram_rd, bus.vram_wr, bus.vram_be, bus.vram_addr}, {2'b10, 4'hF, 23'h000200});
    bus.vram_ack = 1'b1;
    bus.vram_din = 32'h11111111;
    step();
    check_eq("cpurd_hi", {bus.vram_rd, bus.vram_wr, bus.vram_be, bus.vram_addr}, {2'b10, 4'hF, 23'h000204});
    bus.vram_din = 32'h22222222;
    step();
    bus.vram_ack = 1'b0;
    check_eq("cpurd_strobe_off", {bus.vram_rd, bus.vram_wr}, 0);
    check_eq("cpurd_resp", bus.cpu_resp_valid, 1);
    check_eq("cpurd_data", bus.cpu_resp_rdata, 64'h2222222211111111);
    step();
    check_eq("cpurd_resp_end", bus.cpu_resp_valid, 0);

    // CPU write, high half only
    cpu_req(23'h000300, 1'b1, 64'hAABBCCDD_00000000, 8'hF0);
    #1;
    check_eq("wrf0_gnt", bus.cpu_req_ready, 1);
    step();
    bus.cpu_req_valid = 1'b0;
    check_eq("wrf0_beat", {bus.vram_rd, bus.vram_wr, bus.vram_be, bus.vram_addr}, {2'b01, 4'hF, 23'h000304});
    check_eq("wrf0_dout", bus.vram_dout, 32'hAABBCCDD);
    bus.vram_ack = 1'b1;
    step();
    bus.vram_ack = 1'b0;
    check_eq("wrf0_resp", {bus.vram_wr, bus.cpu_resp_valid}, 2'b01);
    check_eq("wrf0_rdata", bus.cpu_resp_rdata, 0);
    step();

    // CPU write with empty mask: response without any VRAM cycle
    cpu_req(23'h000308, 1'b1, 64'h1, 8'h00);
    #1;
    check_eq("wr00_gnt", bus.cpu_req_ready, 1);
    step();
    bus.cpu_req_valid = 1'b0;
    check_eq("wr00_resp", {bus.vram_rd, bus.vram_wr, bus.cpu_resp_valid}, 3'b001);
    step();

    // ack held off five cycles: beat fields stable throughout
    cpu_req(23'h000500, 1'b1, 64'h12345678_9ABCDEF0, 8'hFF);
    #1;
    check_eq("hold_gnt", bus.cpu_req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      bus.cpu_req_valid = 1'b0;
      check_eq("hold_lo", {bus.vram_rd, bus.vram_wr, bus.vram_be, bus.vram_addr, bus.vram_dout},
               {2'b01, 4'hF, 23'h000500, 32'h9ABCDEF0});
      bus.vram_ack = (i == 5);
    end
    step();
    check_eq("hold_hi", {bus.vram_rd, bus.vram_wr, bus.vram_be, bus.vram_addr, bus.vram_dout},
             {2'b01, 4'hF, 23'h000504, 32'h12345678});
    step();
    bus.vram_ack = 1'b0;
    check_eq("hold_resp", {bus.vram_wr, bus.cpu_resp_valid}, 2'b01);
    step();
    bus.vram_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("spur_ack", {bus.vram_rd, bus.vram_wr, bus.cpu_resp_valid, bus.pvr_resp_valid}, 0);
    end
    bus.vram_ack = 1'b0;

    // reset while CPU_HI awaits ack
    cpu_req(23'h000400, 1'b0, 64'h0, 8'hFF);
    step();
    bus.cpu_req_valid = 1'b0;
    bus.vram_ack = 1'b1;
    bus.vram_din = 32'h55555555;
    step();
    bus.vram_ack = 1'b0;
    check_eq("mid_hi", {bus.vram_rd, bus.vram_addr}, {1'b1, 23'h000404});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_strobe", {bus.vram_rd, bus.vram_wr, bus.vram_be}, 0);
    check_eq("mid_addr", bus.vram_addr, 0);
    check_eq("mid_rdata", {bus.cpu_resp_rdata, bus.pvr_resp_rdata[0]}, 0);
    check_eq("mid_pvr_rdata", bus.pvr_resp_rdata, 0);
    bus.vram_ack = 1'b1;
    step();
    check_eq("mid_late_ack", {bus.vram_rd, bus.cpu_resp_valid, bus.pvr_resp_valid}, 0);
    bus.vram_ack = 1'b0;
    bus.pvr_req_valid = 1'b1;
    bus.pvr_req_addr  = 23'h000600;
    #1;
    check_eq("mid_idle_gnt", bus.pvr_req_ready, 1);
    step();
    bus.pvr_req_valid = 1'b0;
    check_eq("mid_no_resp", {bus.cpu_resp_valid, bus.pvr_resp_valid}, 0);
    bus.vram_ack = 1'b1;
    step();
    bus.vram_ack = 1'b0;
    step();

    // starvation: both requesters always valid, VRAM acks immediately
    cpu_req(23'h000700, 1'b0, 64'h0, 8'hFF);
    bus.pvr_req_valid = 1'b1;
    bus.pvr_req_addr  = 23'h000800;
    bus.vram_ack      = 1'b1;
    wcnt = 0;
    ng   = 0;
    seq  = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      check_eq("stv_excl", bus.cpu_req_ready & bus.pvr_req_ready, 0);
      if (bus.cpu_req_ready || bus.pvr_req_ready) begin
        check_eq("stv_winner", bus.cpu_req_ready, (wcnt >= 8));
        if (ng < 5) seq[ng] = bus.cpu_req_ready;
        ng++;
      end
      if (bus.cpu_req_ready) wcnt = 0;
      else if (wcnt < 255) wcnt++;
      step();
    end
    check_eq("stv_order", seq, 5'b01000);
    bus.cpu_req_valid = 1'b0;
    bus.pvr_req_valid = 1'b0;
    repeat (6) step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // randomized traffic against the beat-queue model
    wcnt = 0; inflight = 0; owner_cpu = 0; cpu_pend = 0; pvr_pend = 0;
    due_cpu = 0; due_pvr = 0; exp_cpu_rdata = '0; exp_pvr_rdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      strobe = bus.vram_rd | bus.vram_wr;
      check_eq("r_excl", bus.vram_rd & bus.vram_wr, 0);
      check_eq("r_cpu_resp", bus.cpu_resp_valid, due_cpu);
      check_eq("r_pvr_resp", bus.pvr_resp_valid, due_pvr);
      if (due_cpu) check_eq("r_cpu_data", bus.cpu_resp_rdata, exp_cpu_rdata);
      if (due_pvr) check_eq("r_pvr_data", bus.pvr_resp_rdata, exp_pvr_rdata);
      if (strobe) begin
        if (beats.size() == 0) begin
          check_eq("r_strobe_unexp", 1, 0);
        end else begin
          b = beats[0];
          check_eq("r_beat", {bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wr ? bus.vram_dout : 32'h0},
                   {b.wr, b.addr, b.be, b.wr ? b.dout : 32'h0});
        end
      end else begin
        check_eq("r_strobe_miss", beats.size() != 0, 0);
      end

      if (!cpu_pend && $urandom_range(0, 3) == 0) begin
        cpu_pend = 1;
        bus.cpu_req_addr  = 23'($urandom_range(0, 255));
        bus.cpu_req_wen   = 1'($urandom_range(0, 1));
        bus.cpu_req_wdata = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0:       bus.cpu_req_wmask = 8'h00;
          1:       bus.cpu_req_wmask = 8'h0F;
          2:       bus.cpu_req_wmask = 8'hF0;
          default: bus.cpu_req_wmask = 8'($urandom);
        endcase
      end
      if (!pvr_pend && $urandom_range(0, 2) == 0) begin
        pvr_pend = 1;
        bus.pvr_req_addr = 23'($urandom_range(0, 255));
      end
      bus.cpu_req_valid = cpu_pend;
      bus.pvr_req_valid = pvr_pend;
      bus.vram_ack = strobe ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if (bus.vram_rd && beats.size() != 0) bus.vram_din = read_mem(int'(beats[0].addr[22:2]));
      else bus.vram_din = $urandom;
      #1;

      exp_cg = !inflight && cpu_pend && (!pvr_pend || wcnt >= 8);
      exp_pg = !inflight && pvr_pend && !exp_cg;
      check_eq("r_cpu_gnt", bus.cpu_req_ready, exp_cg);
      check_eq("r_pvr_gnt", bus.pvr_req_ready, exp_pg);

      nxt_cpu = 0;
      nxt_pvr = 0;
      if (due_cpu || due_pvr) inflight = 0;
      if (bus.vram_ack && strobe && beats.size() != 0) begin
        b = beats.pop_front();
        if (b.wr) begin
          wv = read_mem(int'(b.addr[22:2]));
          for (int j = 0; j < 4; j++) if (b.be[j]) wv[8*j +: 8] = b.dout[8*j +: 8];
          mem[int'(b.addr[22:2])] = wv;
        end
        if (beats.size() == 0) begin
          if (owner_cpu) nxt_cpu = 1;
          else nxt_pvr = 1;
        end
      end
      if (exp_cg) begin
        inflight  = 1;
        owner_cpu = 1;
        cpu_pend  = 0;
        base = {bus.cpu_req_addr[22:3], 3'b000};
        if (!bus.cpu_req_wen) begin
          beats.push_back({1'b0, base, 32'h0, 4'hF});
          beats.push_back({1'b0, base + 23'd4, 32'h0, 4'hF});
          exp_cpu_rdata = {read_mem(int'(base[22:2]) + 1), read_mem(int'(base[22:2]))};
        end else begin
          exp_cpu_rdata = '0;
          if (bus.cpu_req_wmask[3:0] != 0)
            beats.push_back({1'b1, base, bus.cpu_req_wdata[31:0], bus.cpu_req_wmask[3:0]});
          if (bus.cpu_req_wmask[7:4] != 0)
            beats.push_back({1'b1, base + 23'd4, bus.cpu_req_wdata[63:32], bus.cpu_req_wmask[7:4]});
          if (bus.cpu_req_wmask == 0) nxt_cpu = 1;
        end
      end else if (exp_pg) begin
        inflight  = 1;
        owner_cpu = 0;
        pvr_pend  = 0;
        base = {bus.pvr_req_addr[22:2], 2'b00};
        beats.push_back({1'b0, base, 32'h0, 4'hF});
        exp_pvr_rdata = read_mem(int'(base[22:2]));
      end
      if (exp_cg) wcnt = 0;
      else if (bus.cpu_req_valid && wcnt < 255) wcnt++;
      step();
      due_cpu = nxt_cpu;
      due_pvr = nxt_pvr;
    end

    idle_inputs();
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
